// File: rtl/gen_seq_pkg.sv
// Shared definitions for the conware generation sequencer: FSM encoding and
// default grid geometry with the derived pixel-index width.
package gen_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2
  } seq_state_t;

  localparam int GRID_WIDTH  = 4;
  localparam int GRID_HEIGHT = 4;
  localparam int GRID_N      = GRID_WIDTH * GRID_HEIGHT;

  // A one-pixel grid still needs a one-bit counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GRID_IDX_W = idx_width(GRID_N);

endpackage

// File: rtl/conware_pixel_codec.sv
// Combinational mapping between grid state bits and stream colors, plus the
// unknown-color flag used when GEN_ERR_CHECK_EN is defined.
module conware_pixel_codec #(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] alive_color,
  input  logic [DWIDTH-1:0] dead_color,
  input  logic              state_bit,
  output logic [DWIDTH-1:0] color,
  input  logic [DWIDTH-1:0] pixel,
  output logic              pixel_alive,
  output logic              pixel_unknown
);

  assign color         = state_bit ? alive_color : dead_color;
  assign pixel_alive   = (pixel == alive_color);
  assign pixel_unknown = (pixel != alive_color) && (pixel != dead_color);

endmodule

// File: rtl/conware_gen_sequencer.sv
// Drives the conware core for a requested number of generations over AXIS.
// Optional protocol checking on the result stream: define GEN_ERR_CHECK_EN.
module conware_gen_sequencer
  import gen_seq_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int WIDTH  = GRID_WIDTH,
  parameter int HEIGHT = GRID_HEIGHT,
  parameter int GEN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [DWIDTH-1:0]       alive_color,
  input  logic [DWIDTH-1:0]       dead_color,
  input  logic [WIDTH*HEIGHT-1:0] seed_states,
  input  logic [GEN_W-1:0]        num_generations,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [GEN_W-1:0]        gen_count,
  output logic [WIDTH*HEIGHT-1:0] final_states,
  output logic                    error,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output logic [DWIDTH-1:0]       M_AXIS_TDATA,
  output logic                    M_AXIS_TLAST,
  input  logic                    S_AXIS_TVALID,
  output logic                    S_AXIS_TREADY,
  input  logic [DWIDTH-1:0]       S_AXIS_TDATA,
  input  logic                    S_AXIS_TLAST
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  seq_state_t       state;
  logic [IW-1:0]    idx;
  logic [N-1:0]     grid;
  logic [N-1:0]     grid_next;
  logic [GEN_W-1:0] target;
  logic [GEN_W-1:0] gen_inc;
  logic             last_beat;
  logic             rx_alive;
  logic             rx_unknown;
  logic             frame_err;

  conware_pixel_codec #(.DWIDTH(DWIDTH)) u_codec (
    .alive_color   (alive_color),
    .dead_color    (dead_color),
    .state_bit     (grid[idx]),
    .color         (M_AXIS_TDATA),
    .pixel         (S_AXIS_TDATA),
    .pixel_alive   (rx_alive),
    .pixel_unknown (rx_unknown)
  );

  // Handshake: a beat moves on a cycle where TVALID and TREADY are both high
  // at the rising edge; TDATA/TLAST come from registers only, so they cannot
  // change while the master is stalled.
  assign last_beat     = (idx == LAST_IDX);
  assign busy          = (state != IDLE);
  assign M_AXIS_TVALID = (state == SEND);
  assign M_AXIS_TLAST  = (state == SEND) && last_beat;
  assign S_AXIS_TREADY = (state == RECV);
  assign gen_inc       = gen_count + 1'b1;

  always_comb begin
    grid_next      = grid;
    grid_next[idx] = rx_alive;
  end

`ifdef GEN_ERR_CHECK_EN
  assign frame_err = rx_unknown || (S_AXIS_TLAST != last_beat);
`else
  logic unused_rx;
  assign unused_rx = ^{S_AXIS_TLAST, rx_unknown};
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      idx          <= '0;
      grid         <= '0;
      target       <= '0;
      gen_count    <= '0;
      final_states <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            grid      <= seed_states;
            target    <= num_generations;
            gen_count <= '0;
            error     <= 1'b0;
            idx       <= '0;
            if (num_generations == '0) begin
              final_states <= seed_states;
              done         <= 1'b1;
            end else begin
              state <= SEND;
            end
          end
        end
        SEND: begin
          if (M_AXIS_TREADY) begin
            if (last_beat) begin
              idx   <= '0;
              state <= RECV;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        RECV: begin
          if (S_AXIS_TVALID) begin
            grid <= grid_next;
            if (frame_err) error <= 1'b1;
            // Frame boundary is the beat count; TLAST only feeds the checker.
            if (last_beat) begin
              idx       <= '0;
              gen_count <= gen_inc;
              if (gen_inc == target) begin
                final_states <= grid_next;
                done         <= 1'b1;
                state        <= IDLE;
              end else begin
                state <= SEND;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conware_gen_sequencer.sv
// Self-checking bench for conware_gen_sequencer with a behavioural responder
// standing in for the conware core (Life step, inversion, identity or random).
module tb_conware_gen_sequencer;

  localparam int DW = 32;
  localparam int N  = 16;
  localparam int GW = 16;
  localparam logic [DW-1:0] ALIVE = 32'hA1B2C3D4;
  localparam logic [DW-1:0] DEAD  = 32'h10203040;
  localparam logic [DW-1:0] JUNK  = 32'h0BAD0BAD;
  localparam int M_LIFE = 0, M_INV = 1, M_ID = 2, M_RAND = 3;
`ifdef GEN_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]  seed_states = '0;
  logic [GW-1:0] num_generations = '0;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic [GW-1:0] gen_count;
  logic [N-1:0]  final_states;
  logic          M_AXIS_TVALID, M_AXIS_TLAST, S_AXIS_TREADY;
  logic [DW-1:0] M_AXIS_TDATA;
  logic          M_AXIS_TREADY = 1'b0;
  logic          S_AXIS_TVALID = 1'b0;
  logic [DW-1:0] S_AXIS_TDATA = '0;
  logic          S_AXIS_TLAST = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  conware_gen_sequencer dut (
    .clk (clk), .rstn (rstn),
    .alive_color (ALIVE), .dead_color (DEAD),
    .seed_states (seed_states), .num_generations (num_generations),
    .start (start), .busy (busy), .done (done), .gen_count (gen_count),
    .final_states (final_states), .error (error),
    .M_AXIS_TVALID (M_AXIS_TVALID), .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TDATA (M_AXIS_TDATA), .M_AXIS_TLAST (M_AXIS_TLAST),
    .S_AXIS_TVALID (S_AXIS_TVALID), .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TDATA (S_AXIS_TDATA), .S_AXIS_TLAST (S_AXIS_TLAST)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  function automatic logic [DW-1:0] color_of(input logic b);
    return b ? ALIVE : DEAD;
  endfunction

  function automatic logic [N-1:0] life_step(input logic [N-1:0] g);
    logic [N-1:0] nx;
    nx = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 4 &&
                c + dc >= 0 && c + dc < 4 && g[(r + dr) * 4 + c + dc])
              cnt++;
          end
        end
        nx[r * 4 + c] = (cnt == 3) || (g[r * 4 + c] && cnt == 2);
      end
    end
    return nx;
  endfunction

  function automatic logic [N-1:0] respond(input int mode, input logic [N-1:0] g);
    case (mode)
      M_LIFE:  return life_step(g);
      M_INV:   return ~g;
      M_ID:    return g;
      default: return N'($urandom);
    endcase
  endfunction

  // Driver: one complete run; frame contents are checked against the model.
  task automatic run_gen(input logic [N-1:0] seed, input logic [GW-1:0] ngen,
                         input int mode, input int rdy_mode, input int bad_last,
                         input int bad_pix, output logic [N-1:0] final_out);
    logic [N-1:0]  cur, nxt;
    logic [DW-1:0] prev_data, exp_c;
    logic          prev_last, stalled, toggle, r, v, pend;
    int            beats, wait_cyc;
    final_out = 'x;
    @(negedge clk);
    seed_states = seed; num_generations = ngen; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("error_cleared_on_start", error, 1'b0);
    if (ngen == 0) begin
      chk("zero_gen_done", done, 1'b1);
      chk("zero_gen_final", final_states, seed);
      chk("zero_gen_tvalid", M_AXIS_TVALID, 1'b0);
      chk("zero_gen_busy", busy, 1'b0);
      chk("zero_gen_count", gen_count, '0);
      @(negedge clk);
      chk("zero_gen_done_pulse", done, 1'b0);
      chk("zero_gen_tvalid2", M_AXIS_TVALID, 1'b0);
      final_out = final_states;
      return;
    end
    chk("tvalid_after_start", M_AXIS_TVALID, 1'b1);
    cur = seed;
    for (int f = 0; f < int'(ngen); f++) begin
      for (int k = 0; k < N; k++) exp_q.push_back(color_of(cur[k]));
      beats = 0; wait_cyc = 0; stalled = 1'b0; toggle = 1'b0;
      prev_data = '0; prev_last = 1'b0;
      while (beats < N && wait_cyc < 200) begin
        if (M_AXIS_TVALID) begin
          if (stalled) begin
            chk("m_tdata_stable", M_AXIS_TDATA, prev_data);
            chk("m_tlast_stable", M_AXIS_TLAST, prev_last);
          end
          case (rdy_mode)
            0:       r = 1'b1;
            1:       begin toggle = ~toggle; r = toggle; end
            default: r = 1'($urandom_range(0, 1));
          endcase
          M_AXIS_TREADY = r;
          if (r) begin
            exp_c = exp_q.pop_front();
            chk("m_tdata", M_AXIS_TDATA, exp_c);
            chk("m_tlast", M_AXIS_TLAST, beats == N - 1);
            beats++;
          end
          stalled = !r; prev_data = M_AXIS_TDATA; prev_last = M_AXIS_TLAST;
        end
        @(negedge clk);
        wait_cyc++;
      end
      M_AXIS_TREADY = 1'b0;
      if (beats < N) begin
        chk("m_frame_timeout", beats, N);
        exp_q.delete();
        return;
      end
      chk("m_tvalid_low_in_recv", M_AXIS_TVALID, 1'b0);
      nxt = respond(mode, cur);
      if (f == 0 && bad_pix >= 0) nxt[bad_pix] = 1'b0;
      beats = 0; wait_cyc = 0; pend = 1'b0;
      while (beats < N && wait_cyc < 200) begin
        if (pend) begin
          chk("error_next_cycle", error, ERR_EN);
          pend = 1'b0;
        end
        v = ($urandom_range(0, 3) != 0);
        S_AXIS_TVALID = v;
        S_AXIS_TDATA  = (f == 0 && beats == bad_pix) ? JUNK : color_of(nxt[beats]);
        S_AXIS_TLAST  = v && ((beats == N - 1) ^ (f == 0 && beats == bad_last));
        if (v && S_AXIS_TREADY) begin
          if (f == 0 && (beats == bad_last || beats == bad_pix)) pend = 1'b1;
          beats++;
        end
        @(negedge clk);
        wait_cyc++;
      end
      S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
      if (beats < N) begin
        chk("s_frame_timeout", beats, N);
        return;
      end
      cur = nxt;
      if (f == int'(ngen) - 1) begin
        chk("done_at_end", done, 1'b1);
        chk("gen_count_end", gen_count, ngen);
        chk("busy_at_end", busy, 1'b0);
        chk("final_vs_model", final_states, cur);
      end else begin
        chk("no_early_done", done, 1'b0);
        chk("gen_count_mid", gen_count, GW'(f + 1));
        chk("resend_tvalid", M_AXIS_TVALID, 1'b1);
      end
    end
    chk("error_at_done", error, ERR_EN && (bad_last >= 0 || bad_pix >= 0));
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("gen_count_hold", gen_count, ngen);
    final_out = final_states;
  endtask

  typedef struct {
    logic [N-1:0]  seed;
    logic [GW-1:0] ngen;
    int            mode;
    int            rdy;
    int            bad_last;
    int            bad_pix;
    logic [N-1:0]  exp_final;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [N-1:0] fo;
    vecs[0] = '{16'h0660, 16'd0, M_LIFE, 0, -1, -1, 16'h0660};
    vecs[1] = '{16'h0660, 16'd3, M_LIFE, 0, -1, -1, 16'h0660};
    vecs[2] = '{16'h8001, 16'd1, M_ID,   1, -1, -1, 16'h8001};
    vecs[3] = '{16'h1234, 16'd2, M_INV,  2, -1, -1, 16'h1234};
    vecs[4] = '{16'h1234, 16'd1, M_INV,  0, -1, -1, 16'hEDCB};
    vecs[5] = '{16'h0070, 16'd1, M_LIFE, 2, -1, -1, 16'h0222};
    vecs[6] = '{16'h0660, 16'd1, M_ID,   0,  5, -1, 16'h0660};
    vecs[7] = '{16'h00FF, 16'd1, M_ID,   2, -1,  3, 16'h00F7};
    vecs[8] = '{16'h0001, 16'd1, M_ID,   0, -1, -1, 16'h0001};

    repeat (3) @(negedge clk);
    rstn = 1'b1;
    chk("rst_tvalid", M_AXIS_TVALID, 1'b0);
    chk("rst_tready", S_AXIS_TREADY, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_gen_count", gen_count, '0);
    chk("rst_final", final_states, '0);
    chk("rst_error", error, 1'b0);

    for (int i = 0; i < 9; i++) begin
      run_gen(vecs[i].seed, vecs[i].ngen, vecs[i].mode, vecs[i].rdy,
              vecs[i].bad_last, vecs[i].bad_pix, fo);
      chk($sformatf("vec%0d_final", i), fo, vecs[i].exp_final);
    end

    // start while busy must not restart or retarget the run
    @(negedge clk);
    seed_states = 16'hF00F; num_generations = 16'd1; start = 1'b1;
    @(negedge clk);
    seed_states = 16'h0000; num_generations = 16'd0;
    M_AXIS_TREADY = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b0;
    chk("busy_ignores_start", busy, 1'b1);
    chk("busy_start_beat0", M_AXIS_TDATA, ALIVE);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // reset in the middle of a SEND frame, then restart from beat 0
    seed_states = 16'h5A5B; num_generations = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; M_AXIS_TREADY = 1'b1;
    repeat (7) @(negedge clk);
    chk("mid_send_beat7", M_AXIS_TDATA, DEAD);
    chk("mid_send_busy", busy, 1'b1);
    rstn = 1'b0; M_AXIS_TREADY = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("midrst_tvalid", M_AXIS_TVALID, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_gen_count", gen_count, '0);
    chk("midrst_final", final_states, '0);
    run_gen(16'h5A5B, 16'd1, M_ID, 0, -1, -1, fo);
    chk("after_rst_final", fo, 16'h5A5B);

    // randomized runs against the model's view of each frame
    for (int i = 0; i < 6; i++) begin
      run_gen(N'($urandom), GW'($urandom_range(1, 3)), M_RAND, 2, -1, -1, fo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conware_gen_sequencer.md
Name: conware_gen_sequencer

Overview:
Stream-side initiator and responder that drives the conware core for N generations. It serializes a seed grid into colored pixels on an AXIS master, which feeds conware S_AXIS. It then collects the result frame on an AXIS slave, which is fed by conware M_AXIS, and decodes the colors back to state bits. It re-sends each result until the requested generation count is reached, then presents the final grid.

Parameters:
DWIDTH, 32, pixel/color width
WIDTH, 4, grid columns
HEIGHT, 4, grid rows
GEN_W, 16, width of generation count

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
alive_color  in  DWIDTH  color emitted/decoded for state 1
dead_color  in  DWIDTH  color emitted for state 0
seed_states  in  WIDTH*HEIGHT  initial grid, sampled at start
num_generations  in  GEN_W  generations to run, sampled at start
start  in  1  launch request, honoured only in IDLE
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on run completion
gen_count  out  GEN_W  generations completed in current/last run
final_states  out  WIDTH*HEIGHT  grid after last generation
error  out  1  sticky protocol error (0 unless GEN_ERR_CHECK_EN)
M_AXIS_TVALID  out  1  pixel valid toward conware
M_AXIS_TREADY  in  1
M_AXIS_TDATA  out  DWIDTH
M_AXIS_TLAST  out  1
S_AXIS_TVALID  in  1  pixel valid from conware
S_AXIS_TREADY  out  1
S_AXIS_TDATA  in  DWIDTH
S_AXIS_TLAST  in  1

Behaviour:
- N = WIDTH*HEIGHT. Beat i carries state bit i; bit 0 goes first. Pixel counter is $clog2(N) bits and wraps to 0 after beat N-1.
- Reset (rstn=0 at posedge) forces IDLE with all outputs 0: TVALID, TREADY, busy, done, gen_count, final_states, error. Counter and grid buffer are cleared. Reset mid-run abandons the frame; no partial-frame recovery.
- FSM states: IDLE, SEND, RECV.
  - IDLE: on start=1, latch seed_states into the grid buffer, latch num_generations, clear gen_count and error.
  - If the latched num_generations=0: final_states<=seed, done pulses next cycle, stay in IDLE, no stream traffic.
  - Otherwise go to SEND. M_AXIS_TVALID is high the cycle after start.
- SEND:
  - M_AXIS_TVALID=1.
  - TDATA = buf[idx] ? alive_color : dead_color.
  - TLAST = (idx==N-1).
  - TDATA and TLAST are held stable while TVALID&&!TREADY.
  - idx advances only on TVALID&&TREADY. On the transfer of beat N-1, go to RECV with idx=0.
- RECV:
  - S_AXIS_TREADY=1; M_AXIS_TVALID=0.
  - Each accepted beat writes buf[idx] <= (TDATA==alive_color).
  - Frame length is fixed by beat count, not by TLAST.
  - On acceptance of beat N-1, gen_count increments.
  - If the new count equals the latched num_generations: final_states<=decoded grid, done=1 for one cycle, go to IDLE.
  - Otherwise go to SEND with the decoded grid.
- SEND and RECV never overlap. conware buffers a whole frame before emitting, so there is no deadlock.
- start while busy is ignored. The color inputs are assumed static during a run.
- gen_count saturates naturally because a run terminates at the latched target. It holds its value after done.

Optional Feature:
GEN_ERR_CHECK_EN
- Defined: error is set sticky, cleared only by a start accepted in IDLE or by reset, on any of:
  - an accepted RECV beat with TDATA not equal to alive_color and not equal to dead_color;
  - TLAST=1 on a beat other than N-1;
  - TLAST=0 on beat N-1.
  - Framing is still beat-count based, and the run continues.
- Undefined: error is tied 0 and S_AXIS_TLAST is ignored.

Decomposition:
- Shared package gen_seq_pkg holds:
  - FSM state encoding localparams (IDLE=2'd0, SEND=2'd1, RECV=2'd2);
  - the derived N and index-width constants.
- One natural sub-module: conware_pixel_codec. It is combinational: state bit to color encode, color to state bit decode, and the unknown-color flag used under GEN_ERR_CHECK_EN.

Test Plan:
- num_generations=0, seed=16'h0660, start -> done pulses 1 cycle later, final_states=16'h0660, M_AXIS_TVALID never 1, gen_count=0.
- Full conware core, seed=16'h0660 (still-life 2x2 block), num_generations=3 -> exactly 3 master frames of 16 beats, TLAST only on beat 15, then gen_count=3 and final_states=16'h0660 with done.
- M_AXIS_TREADY toggling 1/0 each cycle -> TDATA/TLAST stable across stalls, exactly 16 transfers, beat 15 alive/dead matches seed bit 15.
- Color-inverting loopback responder, seed=16'h1234, num_generations=2 -> final_states=16'h1234; after 1 generation, internal grid=16'hEDCB.
- rstn=0 for one cycle during SEND at beat 7 -> next cycle TVALID=0, busy=0, gen_count=0. A fresh start resends from beat 0 with TDATA for bit 0.
- With GEN_ERR_CHECK_EN, responder asserts TLAST on beat 5 -> error=1 from the next cycle, held through done; frame still closes at beat 15. The next start clears error to 0.
